// File: rtl/pad_io_pkg.sv
// Shared defaults and types for the pad-side I/O conditioner.
// Holds the synchroniser/filter defaults, the loopback mode encoding and the per-channel response.
package pad_io_pkg;

   localparam int PAD_SYNC_STAGES = 2;
   localparam int PAD_FILT_W      = 4;

   typedef enum logic {
      SRC_PAD      = 1'b0,
      SRC_LOOPBACK = 1'b1
   } src_sel_e;

   localparam src_sel_e PAD_LOOPBACK_MODE = SRC_LOOPBACK;

   typedef struct packed {
      logic level;
      logic rise;
      logic fall;
   } pad_in_rsp_t;

   // Fewer than two flops is not a synchroniser; clamp rather than build a metastable path.
   function automatic int sync_depth(input int n);
      return (n < 2) ? 2 : n;
   endfunction

endpackage

// File: rtl/pad_in_filter.sv
// One input channel: synchroniser chain, glitch filter with run-length counter, and
// registered edge pulses aligned with the first cycle of the new filtered level.
module pad_in_filter
   import pad_io_pkg::*;
#(
   parameter int   SYNC_STAGES = PAD_SYNC_STAGES,
   parameter int   FILT_W      = PAD_FILT_W,
   parameter logic RST_VAL     = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              src,
   input  logic [FILT_W-1:0] filt_len,
   output logic              level,
   output logic              rise,
   output logic              fall
);

   localparam int SN = sync_depth(SYNC_STAGES);

   logic [SN-1:0]     sync_q;
   logic              s;
   logic              f_q, f_d;
   logic [FILT_W-1:0] cnt_q, cnt_d;
   logic              rise_q, rise_d;
   logic              fall_q, fall_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= {SN{RST_VAL}};
      else     sync_q <= {sync_q[SN-2:0], src};
   end

   assign s = sync_q[SN-1];

   // The >= compare lets a lowered filt_len take effect on the very next mismatch,
   // and cnt can never pass filt_len, so it cannot wrap.
   always_comb begin
      f_d    = f_q;
      cnt_d  = '0;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (s != f_q) begin
         if (cnt_q >= filt_len) begin
            f_d    = s;
            rise_d = s;
            fall_d = ~s;
         end else begin
            cnt_d = cnt_q + FILT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f_q    <= RST_VAL;
         cnt_q  <= '0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         f_q    <= f_d;
         cnt_q  <= cnt_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign level = f_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: rtl/pad_io_ctrl.sv
// Multi-channel pad I/O conditioner: per-channel input filters, registered output
// data/enable, and an internal loopback that feeds pad_out_o back into the filters.
module pad_io_ctrl
   import pad_io_pkg::*;
#(
   parameter int                NUM_CH      = 4,
   parameter int                SYNC_STAGES = PAD_SYNC_STAGES,
   parameter int                FILT_W      = PAD_FILT_W,
   parameter logic [NUM_CH-1:0] RST_VAL     = {NUM_CH{1'b1}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] pad_in_i,
   input  logic [FILT_W-1:0] filt_len_i,
   input  logic              loopback_i,
   input  logic [NUM_CH-1:0] core_out_i,
   input  logic [NUM_CH-1:0] core_oe_i,
   output logic [NUM_CH-1:0] core_in_o,
   output logic [NUM_CH-1:0] rise_o,
   output logic [NUM_CH-1:0] fall_o,
   output logic [NUM_CH-1:0] pad_out_o,
   output logic [NUM_CH-1:0] pad_oe_o
);

   logic                     lb_sel;
   logic [NUM_CH-1:0]        src;
   pad_in_rsp_t [NUM_CH-1:0] rsp;

   assign lb_sel = (src_sel_e'(loopback_i) == PAD_LOOPBACK_MODE);

   // Switching the source is just another input change; the filters absorb it.
   assign src = lb_sel ? pad_out_o : pad_in_i;

   // Pads stay high-Z in reset and whenever loopback owns the input path.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pad_out_o <= '0;
         pad_oe_o  <= '0;
      end else begin
         pad_out_o <= core_out_i;
         pad_oe_o  <= core_oe_i & ~{NUM_CH{lb_sel}};
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      pad_in_filter #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILT_W      (FILT_W),
         .RST_VAL     (RST_VAL[i])
      ) u_filt (
         .clk      (clk),
         .rst      (rst),
         .src      (src[i]),
         .filt_len (filt_len_i),
         .level    (rsp[i].level),
         .rise     (rsp[i].rise),
         .fall     (rsp[i].fall)
      );

      assign core_in_o[i] = rsp[i].level;
      assign rise_o[i]    = rsp[i].rise;
      assign fall_o[i]    = rsp[i].fall;
   end

endmodule

// File: tb/tb_pad_io_ctrl.sv
// Directed bench for pad_io_ctrl: a per-cycle vector table plus hand-written
// sequences for filter-length change, loopback and asynchronous reset mid-count.
module tb_pad_io_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] pad_in_i, filt_len_i, core_out_i, core_oe_i;
   logic       loopback_i;
   logic [3:0] core_in_o, rise_o, fall_o, pad_out_o, pad_oe_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pad_io_ctrl #(.NUM_CH(4), .SYNC_STAGES(2), .FILT_W(4), .RST_VAL(4'hF)) dut (
      .clk        (clk),
      .rst        (rst),
      .pad_in_i   (pad_in_i),
      .filt_len_i (filt_len_i),
      .loopback_i (loopback_i),
      .core_out_i (core_out_i),
      .core_oe_i  (core_oe_i),
      .core_in_o  (core_in_o),
      .rise_o     (rise_o),
      .fall_o     (fall_o),
      .pad_out_o  (pad_out_o),
      .pad_oe_o   (pad_oe_o)
   );

   typedef struct packed {
      logic       r;
      logic [3:0] pin, len;
      logic       lb;
      logic [3:0] co, oe;
      logic [3:0] ein, er, ef, epo, epoe;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic [3:0] pin, len, input logic lb,
                               input logic [3:0] co, oe, ein, er, ef, epo, epoe);
      vec_t v;
      v = '{r, pin, len, lb, co, oe, ein, er, ef, epo, epoe};
      return v;
   endfunction

   task automatic check(input string name, input logic [3:0] ein, er, ef, epo, epoe);
      n_tests++;
      if ({core_in_o, rise_o, fall_o, pad_out_o, pad_oe_o} !== {ein, er, ef, epo, epoe}) begin
         n_fail++;
         $display("FAIL %s: got in=%h rise=%h fall=%h pout=%h poe=%h, want in=%h rise=%h fall=%h pout=%h poe=%h",
                  name, core_in_o, rise_o, fall_o, pad_out_o, pad_oe_o, ein, er, ef, epo, epoe);
      end
   endtask

   // Inputs applied now, outputs checked 1 time unit after the next rising edge.
   task automatic step(input string name, input vec_t v);
      rst        = v.r;
      pad_in_i   = v.pin;
      filt_len_i = v.len;
      loopback_i = v.lb;
      core_out_i = v.co;
      core_oe_i  = v.oe;
      @(posedge clk);
      #1;
      check(name, v.ein, v.er, v.ef, v.epo, v.epoe);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // reset hold with arbitrary inputs, release, L=0 bypass on ch0
      vecs.push_back(mk(1, 4'h6, 0, 0, 4'hA, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0));
      vecs.push_back(mk(1, 4'h9, 0, 0, 4'h5, 4'h3, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0));
      vecs.push_back(mk(0, 4'hF, 0, 0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0));
      vecs.push_back(mk(0, 4'hE, 0, 0, 4'h3, 4'h5, 4'hF, 4'h0, 4'h0, 4'h3, 4'h5));
      vecs.push_back(mk(0, 4'hE, 0, 0, 4'hC, 4'hA, 4'hF, 4'h0, 4'h0, 4'hC, 4'hA));
      vecs.push_back(mk(0, 4'hE, 0, 0, 4'hC, 4'hA, 4'hE, 4'h0, 4'h1, 4'hC, 4'hA));
      vecs.push_back(mk(0, 4'hE, 0, 0, 4'hC, 4'hA, 4'hE, 4'h0, 4'h0, 4'hC, 4'hA));
      // L=3: 3-cycle low glitch on ch1 is swallowed
      for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 4'hC, 3, 0, 4'hC, 4'hA, 4'hE, 4'h0, 4'h0, 4'hC, 4'hA));
      for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 4'hE, 3, 0, 4'hC, 4'hA, 4'hE, 4'h0, 4'h0, 4'hC, 4'hA));
      // 4-cycle low passes after edge 2+3, then a 4-cycle high brings it back
      for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 4'hC, 3, 0, 4'hC, 4'hA, 4'hE, 4'h0, 4'h0, 4'hC, 4'hA));
      vecs.push_back(mk(0, 4'hE, 3, 0, 4'hC, 4'hA, 4'hE, 4'h0, 4'h0, 4'hC, 4'hA));
      vecs.push_back(mk(0, 4'hE, 3, 0, 4'hC, 4'hA, 4'hC, 4'h0, 4'h2, 4'hC, 4'hA));
      for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 4'hE, 3, 0, 4'hC, 4'hA, 4'hC, 4'h0, 4'h0, 4'hC, 4'hA));
      vecs.push_back(mk(0, 4'hE, 3, 0, 4'hC, 4'hA, 4'hE, 4'h2, 4'h0, 4'hC, 4'hA));
      vecs.push_back(mk(0, 4'hE, 3, 0, 4'hC, 4'hA, 4'hE, 4'h0, 4'h0, 4'hC, 4'hA));

      for (int i = 0; i < vecs.size(); i++)
         step($sformatf("vec%0d", i), vecs[i]);

      // L=7 mismatch on ch2 for 3 counted cycles, then L=1 updates on the next cycle
      for (int i = 0; i < 5; i++)
         step($sformatf("flen_hold%0d", i), mk(0, 4'hA, 7, 0, 4'hC, 4'hA, 4'hE, 4'h0, 4'h0, 4'hC, 4'hA));
      step("flen_drop", mk(0, 4'hA, 1, 0, 4'hC, 4'hA, 4'hA, 4'h0, 4'h4, 4'hC, 4'hA));
      step("flen_after", mk(0, 4'hA, 1, 0, 4'hC, 4'hA, 4'hA, 4'h0, 4'h0, 4'hC, 4'hA));

      // loopback: preload pad_out, then route it back with pad_in_i held at a different value
      step("lb_pre", mk(0, 4'hA, 0, 0, 4'h5, 4'hF, 4'hA, 4'h0, 4'h0, 4'h5, 4'hF));
      step("lb_on0", mk(0, 4'h0, 0, 1, 4'h5, 4'hF, 4'hA, 4'h0, 4'h0, 4'h5, 4'h0));
      step("lb_on1", mk(0, 4'h0, 0, 1, 4'h5, 4'hF, 4'hA, 4'h0, 4'h0, 4'h5, 4'h0));
      step("lb_on2", mk(0, 4'h0, 0, 1, 4'h5, 4'hF, 4'h5, 4'h5, 4'hA, 4'h5, 4'h0));
      step("lb_rt0", mk(0, 4'h0, 0, 1, 4'h6, 4'hF, 4'h5, 4'h0, 4'h0, 4'h6, 4'h0));
      step("lb_rt1", mk(0, 4'h0, 0, 1, 4'h6, 4'hF, 4'h5, 4'h0, 4'h0, 4'h6, 4'h0));
      step("lb_rt2", mk(0, 4'h0, 0, 1, 4'h6, 4'hF, 4'h5, 4'h0, 4'h0, 4'h6, 4'h0));
      step("lb_rt3", mk(0, 4'h0, 0, 1, 4'h6, 4'hF, 4'h6, 4'h2, 4'h1, 4'h6, 4'h0));

      // L=5: ch0 mismatch builds cnt to 3, then an asynchronous reset pulse between edges
      step("ar_setup", mk(0, 4'h6, 5, 0, 4'hF, 4'hF, 4'h6, 4'h0, 4'h0, 4'hF, 4'hF));
      for (int i = 0; i < 5; i++)
         step($sformatf("ar_cnt%0d", i), mk(0, 4'h7, 5, 0, 4'hF, 4'hF, 4'h6, 4'h0, 4'h0, 4'hF, 4'hF));
      #2 rst = 1'b1;
      #1 check("ar_async", 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
      #1 rst = 1'b0;
      for (int i = 0; i < 6; i++)
         step($sformatf("ar_post%0d", i), mk(0, 4'hF, 5, 0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
